// File: rtl/mem_xact_initiator.sv
// Single-outstanding memory transaction initiator: command in, one request to the
// responder with optional timeout, one response out. Optional MEM_XACT_SCRAMBLE_EN XORs data.
module mem_xact_initiator #(
  parameter logic [7:0] TIMEOUT = 8'd64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [7:0]  txn_count
);

  // state | meaning
  // IDLE  | waiting for a command, cmd_ready high
  // REQ   | mem_req driven, waiting for mem_ready or timeout
  // RESP  | rsp_valid driven, waiting for rsp_ready

`ifdef MEM_XACT_SCRAMBLE_EN
  localparam logic [31:0] DATA_KEY = 32'hDEADBEEF;
`else
  localparam logic [31:0] DATA_KEY = 32'h0000_0000;
`endif

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state, state_nxt;
  logic        we_q;
  logic        err_q;
  logic [7:0]  tmo_cnt;
  logic [7:0]  tmo_inc;
  logic        tmo_hit;
  logic        cmd_fire;
  logic        rsp_fire;

  assign cmd_ready = (state == IDLE);
  assign mem_req   = (state == REQ);
  assign mem_we    = (state == REQ) && we_q;
  assign rsp_valid = (state == RESP);
  assign rsp_err   = (state == RESP) && err_q;

  assign cmd_fire  = cmd_valid && (state == IDLE);
  assign rsp_fire  = rsp_ready && (state == RESP);

  // Timeout fires on the REQ cycle whose increment would reach TIMEOUT,
  // so REQ lasts exactly TIMEOUT cycles when the responder stays silent.
  assign tmo_inc   = tmo_cnt + 8'd1;
  assign tmo_hit   = (TIMEOUT != 8'd0) && (tmo_inc == TIMEOUT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid)             state_nxt = REQ;
      REQ:     if (mem_ready || tmo_hit)  state_nxt = RESP;
      RESP:    if (rsp_ready)             state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      tmo_cnt   <= 8'd0;
      mem_addr  <= 16'd0;
      mem_wdata <= 32'd0;
      rsp_data  <= 32'd0;
      txn_count <= 8'd0;
    end else begin
      if (cmd_fire) begin
        we_q      <= cmd_write;
        mem_addr  <= cmd_addr;
        mem_wdata <= cmd_wdata ^ DATA_KEY;
        tmo_cnt   <= 8'd0;
      end
      // mem_ready takes priority over a coincident timeout
      if (state == REQ) begin
        if (mem_ready) begin
          rsp_data <= we_q ? 32'd0 : (mem_rdata ^ DATA_KEY);
          err_q    <= 1'b0;
        end else if (tmo_hit) begin
          rsp_data <= 32'd0;
          err_q    <= 1'b1;
        end else begin
          tmo_cnt  <= tmo_inc;
        end
      end
      if (rsp_fire) txn_count <= txn_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_mem_xact_initiator.sv
// Self-checking bench: transaction-level reference model plus directed literal checks
// and a randomized phase; honours MEM_XACT_SCRAMBLE_EN.
module tb_mem_xact_initiator;

  localparam logic [7:0] TMO = 8'd4;
`ifdef MEM_XACT_SCRAMBLE_EN
  localparam logic [31:0] KEY       = 32'hDEADBEEF;
  localparam logic [31:0] READ_EXP  = 32'hCC99E897;
  localparam logic [31:0] WRITE_EXP = 32'h14534EE2;
`else
  localparam logic [31:0] KEY       = 32'h0;
  localparam logic [31:0] READ_EXP  = 32'h12345678;
  localparam logic [31:0] WRITE_EXP = 32'hCAFEF00D;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [15:0] cmd_addr = 16'h0;
  logic [31:0] cmd_wdata = 32'h0, mem_rdata = 32'h0;
  logic        mem_ready = 1'b0, rsp_ready = 1'b0;
  logic        cmd_ready, mem_req, mem_we, rsp_valid, rsp_err;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, rsp_data;
  logic [7:0]  txn_count;

  int n_chk = 0;
  int n_err = 0;

  mem_xact_initiator #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction at a time, tracked as "outstanding" and
  // "response ready", with a count of request cycles spent waiting.
  bit          m_out = 0;
  bit          m_have_rsp = 0;
  bit          m_write = 0;
  bit          m_err = 0;
  int          m_wait = 0;
  logic [15:0] m_addr = 16'h0;
  logic [31:0] m_wdata = 32'h0;
  logic [31:0] m_data = 32'h0;
  int          m_count = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_out = 0; m_have_rsp = 0; m_write = 0; m_err = 0; m_wait = 0;
      m_addr = 16'h0; m_wdata = 32'h0; m_data = 32'h0; m_count = 0;
    end else if (!m_out) begin
      if (cmd_valid) begin
        m_out = 1; m_have_rsp = 0; m_wait = 0;
        m_write = cmd_write; m_addr = cmd_addr; m_wdata = cmd_wdata ^ KEY;
      end
    end else if (!m_have_rsp) begin
      m_wait++;
      if (mem_ready) begin
        m_have_rsp = 1; m_err = 0;
        m_data = m_write ? 32'h0 : (mem_rdata ^ KEY);
      end else if (TMO != 0 && m_wait == int'(TMO)) begin
        m_have_rsp = 1; m_err = 1; m_data = 32'h0;
      end
    end else if (rsp_ready) begin
      m_out = 0; m_have_rsp = 0;
      m_count = (m_count + 1) % 256;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("cmd_ready", cmd_ready, !m_out);
      chk("mem_req", mem_req, m_out && !m_have_rsp);
      chk("mem_we", mem_we, m_out && !m_have_rsp && m_write);
      chk("rsp_valid", rsp_valid, m_have_rsp);
      chk("rsp_err", rsp_err, m_have_rsp && m_err);
      chk("txn_count", txn_count, m_count);
      if (m_out && !m_have_rsp) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
      end
      if (m_have_rsp) chk("rsp_data", rsp_data, m_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quick_write();
    cmd_valid = 1; cmd_write = 1; mem_ready = 1; rsp_ready = 1;
    step();
    cmd_valid = 0;
    step();
    step();
  endtask

  initial begin
    int cnt;
    logic [31:0] held;

    // reset state
    reset = 1;
    repeat (2) step();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rsp_data", rsp_data, 0);
    reset = 0;
    step();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_txn_count", txn_count, 0);

    // read, mem_ready coinciding with the timeout cycle, then backpressure
    cmd_valid = 1; cmd_write = 0; cmd_addr = 16'h0010; cmd_wdata = 32'h0;
    step();
    cmd_valid = 0;
    chk("rd_mem_req_lat1", mem_req, 1);
    chk("rd_mem_addr", mem_addr, 32'h0010);
    repeat (3) step();
    mem_ready = 1; mem_rdata = 32'h12345678;
    step();
    mem_ready = 0; mem_rdata = 32'h0;
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_err", rsp_err, 0);
    chk("rd_rsp_data", rsp_data, READ_EXP);
    held = rsp_data;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = (i == 2);
      cmd_addr  = 16'hBEEF;
      step();
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_rsp_data", rsp_data, held);
    end
    cmd_valid = 0;
    chk("bp_no_accept", mem_req, 0);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    chk("rd_txn_count", txn_count, 1);
    chk("rd_back_idle", cmd_ready, 1);

    // timeout with mem_ready held low
    cmd_valid = 1; cmd_write = 0; cmd_addr = 16'h0020;
    step();
    cmd_valid = 0;
    cnt = 0;
    while (mem_req && cnt < 20) begin
      cnt++;
      step();
    end
    chk("tmo_req_cycles", cnt, 4);
    chk("tmo_rsp_err", rsp_err, 1);
    chk("tmo_rsp_data", rsp_data, 0);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    chk("tmo_txn_count", txn_count, 2);

    // write
    cmd_valid = 1; cmd_write = 1; cmd_addr = 16'h0030; cmd_wdata = 32'hCAFEF00D;
    step();
    cmd_valid = 0;
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_wdata", mem_wdata, WRITE_EXP);
    mem_ready = 1; mem_rdata = 32'h55AA55AA;
    step();
    mem_ready = 0;
    chk("wr_rsp_data", rsp_data, 0);
    rsp_ready = 1;
    step();
    rsp_ready = 0;

    // reset during REQ
    cmd_valid = 1; cmd_write = 0; cmd_addr = 16'h0040;
    step();
    cmd_valid = 0;
    step();
    #2 reset = 1;
    #1;
    chk("rstmid_mem_req", mem_req, 0);
    chk("rstmid_rsp_valid", rsp_valid, 0);
    chk("rstmid_txn_count", txn_count, 0);
    step();
    reset = 0;
    step();
    chk("rstmid_idle", cmd_ready, 1);
    chk("rstmid_no_rsp", rsp_valid, 0);

    // 256 transactions wrap the counter
    for (int i = 0; i < 255; i++) quick_write();
    mem_ready = 0; rsp_ready = 0;
    chk("wrap_255", txn_count, 255);
    quick_write();
    mem_ready = 0; rsp_ready = 0;
    chk("wrap_0", txn_count, 0);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_write = $urandom_range(0, 1);
      cmd_addr  = 16'($urandom);
      cmd_wdata = $urandom;
      mem_rdata = $urandom;
      mem_ready = ($urandom_range(0, 5) == 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    cmd_valid = 0; mem_ready = 0; rsp_ready = 0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
